// File: rtl/srff_pkg.sv
// Shared helpers for the SR flag bank: lowest-set-bit search and popcount.
// Functions work on a 64-bit vector (the widest supported bank); callers
// zero-extend their WIDTH-bit vectors and slice the result to size.
package srff_pkg;

    localparam int MAX_W    = 64;
    localparam int MAX_IDX_W = 6;   // indexes 0..63
    localparam int MAX_PC_W  = 7;   // counts 0..64

    // Index of the lowest set bit, 0 when the vector is all zero.
    function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(input logic [MAX_W-1:0] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (v[i]) idx = i[MAX_IDX_W-1:0];
        end
        return idx;
    endfunction

    // Number of set bits in the vector.
    function automatic logic [MAX_PC_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [MAX_PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_W; i++) begin
            cnt = cnt + {{(MAX_PC_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/srff_bank_ar_rise_det.sv
// Registered rising-edge detector: rise is high in any cycle where d is 1
// and was 0 on the previous clock. History resets to 0, so a bit already
// high when reset is released reads as a rising edge.
module rise_det_ar #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] d_q;

    // One-cycle history of d, updated unconditionally every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= '0;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/srff_bank_ar.sv
// Bank of WIDTH sticky SR flags with selectable set/reset priority,
// optional edge-qualified set, per-channel set mask and synchronous clear.
// Also records the first channel to rise and a saturating rise count.
module srff_bank_ar
    import srff_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] POR_VALUE  = '0,
    parameter bit               R_DOMINANT = 1'b1,
    parameter bit               S_EDGE     = 1'b0,
    parameter int               CNT_W      = 8,
    localparam int              IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] mask,
    input  logic             clr_all,
    output logic [WIDTH-1:0] out,
    output logic             any,
    output logic             first_valid,
    output logic [IDX_W-1:0] first_idx,
    output logic [CNT_W-1:0] set_cnt
);

    localparam int PC_W = $clog2(WIDTH + 1);
    // Sum is held wide enough for both operands so a large popcount on a
    // narrow counter cannot wrap before the saturation compare.
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0]     s_qual;
    logic [WIDTH-1:0]     se;
    logic [WIDTH-1:0]     nxt;
    logic [WIDTH-1:0]     rise;
    logic [MAX_W-1:0]     rise_ext;
    logic [MAX_IDX_W-1:0] low_full;
    logic [MAX_PC_W-1:0]  pc_full;
    logic [PC_W-1:0]      pc;
    logic [SUM_W-1:0]     sum;
    logic [CNT_W-1:0]     cnt_nxt;

    // Set qualification: edge detector only when edge mode is selected.
    generate
        if (S_EDGE) begin : g_edge
            rise_det_ar #(.WIDTH(WIDTH)) u_rise_det (
                .clk  (clk),
                .rst  (rst),
                .d    (s),
                .rise (s_qual)
            );
        end else begin : g_level
            assign s_qual = s;
        end
    endgenerate

    assign se = mask & s_qual;

    // Next flag state and the 0->1 transitions it produces.
    always_comb begin
        nxt = out;
        if (clr_all)         nxt = '0;
        else if (R_DOMINANT) nxt = (out | se) & ~r;
        else                 nxt = (out & ~r) | se;
        rise = clr_all ? '0 : (nxt & ~out);
    end

    // Lowest rising index and popcount via the shared helpers.
    always_comb begin
        rise_ext = '0;
        rise_ext[WIDTH-1:0] = rise;
        low_full = lowest_set_idx(rise_ext);
        pc_full  = popcount(rise_ext);
        pc       = pc_full[PC_W-1:0];
    end

    // Saturating counter update.
    always_comb begin
        sum = SUM_W'(set_cnt) + SUM_W'(pc);
        if (sum > CNT_MAX) cnt_nxt = {CNT_W{1'b1}};
        else               cnt_nxt = sum[CNT_W-1:0];
    end

    // Flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out <= POR_VALUE;
        else     out <= nxt;
    end

    // First-rise capture; holds once valid until a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_valid <= 1'b0;
            first_idx   <= '0;
        end else if (clr_all) begin
            first_valid <= 1'b0;
            first_idx   <= '0;
        end else if (!first_valid && (rise != '0)) begin
            first_valid <= 1'b1;
            first_idx   <= low_full[IDX_W-1:0];
        end
    end

    // Rise-event counter; a clear discards same-cycle rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          set_cnt <= '0;
        else if (clr_all) set_cnt <= '0;
        else              set_cnt <= cnt_nxt;
    end

    assign any = |out;

endmodule
